instr_prefetch_fetch: RTL
=========================

# instr_prefetch_fetch

Instruction fetch stage upstream of the single-cycle RV32 core. It generates sequential fetch addresses (PC+4) and issues them to instruction memory over a req/ack handshake, tolerating variable memory latency. Returned words are buffered in a small prefetch FIFO and presented to the core as a valid/ready stream of {pc, instruction}. A branch/jump redirect flushes the buffer and restarts fetch at the new PC.

## Interface
Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  fetch address, valid while mem_req=1
- mem_ack  in  1  memory accepts request and returns data this cycle
- mem_rdata  in  32  instruction word, valid when mem_req&&mem_ack
- redirect  in  1  one-cycle pulse: discard buffered/in-flight fetches
- redirect_pc  in  32  new fetch address, sampled when redirect=1
- inst_valid  out  1  FIFO head valid
- inst_pc  out  32  address of head instruction
- inst_data  out  32  head instruction word
- inst_ready  in  1  core consumes head when inst_valid&&inst_ready
- fill_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FSM states: RUN, DISCARD.
- RUN: mem_req = (fill_count < DEPTH); mem_addr = fetch_pc. Transfer = mem_req&&mem_ack: push {fetch_pc, mem_rdata}, fetch_pc += 4 (mod 2^32).
- Memory contract: once mem_req rises, mem_addr holds unchanged until mem_ack; mem_ack while mem_req=0 ignored.
- Redirect (highest priority), same cycle: FIFO flushed (pointers, count to 0); pop and push suppressed.
  - mem_req=0, or mem_req&&mem_ack: returned data dropped; fetch_pc <= redirect_pc; stay RUN.
  - mem_req&&!mem_ack: pending_pc <= redirect_pc; go DISCARD.
- DISCARD: mem_req=1, mem_addr=old fetch_pc; on mem_ack data dropped, fetch_pc <= pending_pc, go RUN. Further redirect in DISCARD only overwrites pending_pc (and flushes FIFO, already empty).
- FIFO full: no request raised; pop in same cycle does not enable a push (no pass-through); request resumes next cycle.
- Push and pop same cycle with 0<count<DEPTH: count unchanged.
- Empty: inst_valid=0; push reaches head next cycle (no bypass).

## Timing
- Reset (RST=0): state RUN, fetch_pc=RESET_PC, pending_pc=0, count=0, all storage 0; mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_pc=0, inst_data=0, fill_count=0.
- First cycle after RST release: mem_req=1, mem_addr=RESET_PC.
- Latency: transfer in cycle N → inst_valid=1 in N+1.
- Throughput: one instruction/cycle with zero-wait memory (mem_ack tied high) and inst_ready=1.
- Redirect in cycle N → inst_valid=0 in N+1; first new-PC request in N+1 (RUN) or cycle after old ack (DISCARD).
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight request abandoned.

## Configuration
- PREFETCH_STATS_EN defined: adds outputs stall_cycles (32, counts cycles mem_req&&!mem_ack) and flush_count (32, counts redirect pulses); both reset to 0, wrap at 2^32.
- Undefined: those ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package riscv_fetch_pkg: FSM state enum (RUN, DISCARD), PC_STEP=4, INSTR_W=32, default RESET_PC.
- Sub-module prefetch_fifo: synchronous FIFO, parameter DEPTH, 64-bit entry {pc, instr}, push/pop/flush, count output; top holds FSM, fetch_pc, pending_pc.

## Test plan
- Reset, mem_ack=1, inst_ready=1 → mem_addr 0,4,8,… every cycle; inst_pc 0 appears cycle after first ack, then one per cycle.
- inst_ready=0, mem_ack=1, DEPTH=4 → four pushes (pcs 0..C), fill_count=4, mem_req=0; raise inst_ready → pcs 0,4,8,C popped in order, fetch resumes at 0x10.
- mem_ack delayed 3 cycles per request → mem_addr stable throughout each wait; data in order, no duplicates.
- redirect to 0x100 while request to 0x8 unacked → DISCARD, mem_addr stays 0x8 until ack, word dropped, next mem_addr 0x100, first inst_pc 0x100.
- redirect to 0x40 with pop and ack same cycle, FIFO holding 2 entries → inst_valid=0 next cycle, fill_count=0, acked word never appears.
- RST asserted mid-stream with FIFO 3 full → all outputs zero immediately; after release mem_addr=RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package riscv_fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states: RUN issues sequential fetches, DISCARD waits
  // out a request that was in flight when a redirect arrived.
  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  // One prefetch buffer entry: address and the word fetched from it.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} entries.
// Flush has priority over push/pop. A push into a full FIFO and a pop from
// an empty one are ignored. The head is read straight from storage, so a
// pushed entry becomes visible the cycle after the push (no bypass).
module prefetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  fetch_entry_t  mem_reg [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign push_ok = push && !flush && (count_reg != CW'(DEPTH));
  assign pop_ok  = pop  && !flush && (count_reg != '0);

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  assign head_entry = mem_reg[rd_ptr_reg];
  assign count      = count_reg;

endmodule

// File: rtl/instr_prefetch_fetch.sv
// Instruction fetch stage: sequential PC generation, req/ack memory
// handshake, prefetch buffering and redirect handling.
// Optional feature macro: PREFETCH_STATS_EN adds stall_cycles/flush_count.
module instr_prefetch_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   mem_req,
  output logic [INSTR_W-1:0]     mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_W-1:0]     mem_rdata,
  input  logic                   redirect,
  input  logic [INSTR_W-1:0]     redirect_pc,
  output logic                   inst_valid,
  output logic [INSTR_W-1:0]     inst_pc,
  output logic [INSTR_W-1:0]     inst_data,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] fill_count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [31:0]            flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_reg;
  fetch_state_e       state_next;
  logic [INSTR_W-1:0] fetch_pc_reg;
  logic [INSTR_W-1:0] fetch_pc_next;
  logic [INSTR_W-1:0] pending_pc_reg;
  logic [INSTR_W-1:0] pending_pc_next;

  logic               req_int;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic [CW-1:0]      count;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;

  assign fifo_full = (count == CW'(DEPTH));

  // Next-state and request logic for the fetch sequencer.
  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    pending_pc_next = pending_pc_reg;
    req_int         = 1'b0;
    fifo_push       = 1'b0;
    case (state_reg)
      RUN: begin
        // A full buffer holds off the request even if the core pops this
        // cycle; fetching resumes the cycle after space appears.
        req_int = !fifo_full;
        if (redirect) begin
          if (req_int && !mem_ack) begin
            // Memory still owes us a word for the old address: wait it out.
            pending_pc_next = redirect_pc;
            state_next      = DISCARD;
          end else begin
            // Nothing outstanding (or the word just arrived): drop and jump.
            fetch_pc_next = redirect_pc;
          end
        end else if (req_int && mem_ack) begin
          fifo_push     = 1'b1;
          fetch_pc_next = fetch_pc_reg + PC_STEP;
        end
      end
      DISCARD: begin
        // Keep the old address on the bus until memory completes it.
        req_int = 1'b1;
        if (mem_ack) begin
          fetch_pc_next = redirect ? redirect_pc : pending_pc_reg;
          state_next    = RUN;
        end else if (redirect) begin
          pending_pc_next = redirect_pc;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Sequencer state, fetch address and deferred redirect target.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= RUN;
      fetch_pc_reg   <= RESET_PC;
      pending_pc_reg <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      pending_pc_reg <= pending_pc_next;
    end
  end

  // Request is forced low while reset is held.
  assign mem_req  = req_int & RST;
  assign mem_addr = fetch_pc_reg;

  assign push_entry.pc    = fetch_pc_reg;
  assign push_entry.instr = mem_rdata;

  assign fifo_pop = inst_valid && inst_ready && !redirect;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RST),
    .flush      (redirect),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign inst_valid = (count != '0);
  assign inst_pc    = head_entry.pc;
  assign inst_data  = head_entry.instr;
  assign fill_count = count;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;

  // Wait-state and redirect counters; both wrap at 2^32.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (req_int && !mem_ack) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (redirect)            flush_count_reg  <= flush_count_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
